// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads opcode (and operand for long opcodes),
// owns the program counter, and flags reads that wait too long for memory.
module instr_fetch_unit #(
  parameter int PC_W    = 13,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ready,
  output logic [7:0]      ir,
  output logic [7:0]      tr,
  output logic            instr_long,
  output logic            instr_valid,
  output logic            busy,
  output logic            fetch_err,
  output logic [PC_W-1:0] pc
);

  // state     | meaning
  // IDLE      | waiting for fetch_req
  // FETCH_OP  | reading opcode byte at pc
  // FETCH_OPR | reading operand byte at pc (long instructions)
  // DONE      | one-cycle instr_valid pulse to the controller
  typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_OPR, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [7:0]      ir_nxt, tr_nxt, wait_cnt, wait_nxt;
  logic            long_nxt, err_nxt, op_long, timed_out;

  assign busy        = (state == FETCH_OP) || (state == FETCH_OPR);
  assign mem_rd      = busy;
  assign mem_addr    = pc;
  assign instr_valid = (state == DONE);

  assign op_long   = ~mem_rdata[7] | (mem_rdata[7:5] == 3'b110);
  // The terminal wait cycle itself counts, so abort when the counter is one short.
  assign timed_out = busy && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    tr_nxt    = tr;
    long_nxt  = instr_long;
    err_nxt   = fetch_err;

    case (state)
      IDLE: begin
        if (fetch_req) begin
          state_nxt = FETCH_OP;
          err_nxt   = 1'b0;
        end
      end
      FETCH_OP: begin
        if (mem_ready) begin
          ir_nxt    = mem_rdata;
          long_nxt  = op_long;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = op_long ? FETCH_OPR : DONE;
        end else if (timed_out) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      FETCH_OPR: begin
        if (mem_ready) begin
          tr_nxt    = mem_rdata;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = DONE;
        end else if (timed_out) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A jump overrides everything, but a request arriving in IDLE still starts.
    if (pc_load) begin
      pc_nxt    = pc_load_val;
      ir_nxt    = ir;
      tr_nxt    = tr;
      long_nxt  = instr_long;
      err_nxt   = (state == IDLE && fetch_req) ? 1'b0 : fetch_err;
      state_nxt = (state == IDLE && fetch_req) ? FETCH_OP : IDLE;
    end

    wait_nxt = (busy && (state_nxt == state) && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      tr         <= '0;
      instr_long <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir         <= ir_nxt;
      tr         <= tr_nxt;
      instr_long <= long_nxt;
      fetch_err  <= err_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Byte-serial instruction fetch stage sitting directly upstream of the multicycle controller. On a fetch request it reads the opcode byte at PC and decodes instruction length from the opcode. For two-byte instructions it also reads the operand/address byte. It then presents both bytes to the controller with a one-cycle valid pulse. It owns the program counter: increment on every byte read, plus absolute load for jumps.

## Interface
- PC_W, 13, program counter / memory address width (5 bits from IR[4:0] + 8 bits from TR)
- TIMEOUT, 15, max cycles a memory read may wait for mem_ready before aborting (1..255)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- fetch_req  in  1  start fetching the instruction at PC; sampled only when busy=0
- pc_load  in  1  load PC from pc_load_val; valid in any state
- pc_load_val  in  PC_W  jump target
- mem_addr  out  PC_W  byte address to instruction memory
- mem_rd  out  1  read strobe, held until mem_ready
- mem_rdata  in  8  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  memory completes the read this cycle
- ir  out  8  opcode byte
- tr  out  8  operand byte (long instructions only; otherwise holds previous value)
- instr_long  out  1  1 when ir is a two-byte instruction
- instr_valid  out  1  one-cycle pulse: ir/tr/instr_long are final
- busy  out  1  fetch in progress
- fetch_err  out  1  sticky: a read timed out; cleared by the next accepted fetch_req
- pc  out  PC_W  current program counter

## Operation
- States: IDLE, FETCH_OP, FETCH_OPR, DONE. Reset enters IDLE.
- IDLE:
  - busy=0, mem_rd=0.
  - fetch_req=1 → FETCH_OP, clear fetch_err.
- FETCH_OP:
  - mem_rd=1, mem_addr=pc.
  - On mem_ready: ir<=mem_rdata, pc<=pc+1.
  - long = (mem_rdata[7]==0) | (mem_rdata[7:5]==3'b110); instr_long<=long.
  - Next state: FETCH_OPR if long, else DONE.
- FETCH_OPR:
  - mem_rd=1, mem_addr=pc.
  - On mem_ready: tr<=mem_rdata, pc<=pc+1 → DONE.
- DONE: instr_valid=1, busy=0 → IDLE.
- Arithmetic:
  - PC increment wraps modulo 2^PC_W (all-ones → 0).
  - mem_addr equals pc in every state.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH_OP/FETCH_OPR and on every mem_ready.
  - It increments each cycle mem_rd=1 and mem_ready=0.
  - On reaching TIMEOUT: fetch_err<=1, go to IDLE, no instr_valid, pc unchanged for that byte.
- pc_load, highest priority:
  - In any state, pc<=pc_load_val and the FSM goes to IDLE.
  - An in-flight fetch is aborted with no instr_valid; ir/tr keep their last values.
  - If fetch_req=1 in the same cycle while in IDLE: pc loads and the FSM goes to FETCH_OP, reading from pc_load_val next cycle.
- fetch_req while busy=1 or in DONE: ignored (not queued).
- mem_ready while mem_rd=0: ignored.

## Timing
- Reset values: pc=0, ir=0, tr=0, instr_long=0, instr_valid=0, busy=0, mem_rd=0, fetch_err=0, mem_addr=0, wait counter=0.
- busy=1 exactly in FETCH_OP and FETCH_OPR.
- Zero-wait memory (mem_ready tied 1), fetch_req accepted at edge 0:
  - Short instruction: FETCH_OP in cycle 1; instr_valid in cycle 2.
  - Long instruction: FETCH_OP in cycle 1; FETCH_OPR in cycle 2; instr_valid in cycle 3.
- Each wait cycle with mem_ready=0 adds one cycle.
- ir, tr, instr_long and pc are registered and stable from the DONE cycle until the next byte capture.
- The controller may issue the next fetch_req in the DONE cycle, but it is ignored. The earliest accepted request is in the cycle after DONE, i.e. in IDLE.

## Test plan
- Short opcode, zero-wait: mem[0]=0xA5, fetch_req at cycle 0.
  - Required: instr_valid at cycle 2, ir=0xA5, instr_long=0, pc=1, tr=0.
- Long opcode with waits: mem[0]=0x42, mem[1]=0x3C, mem_ready delayed 2 cycles per read.
  - Required: instr_valid at cycle 7, ir=0x42, tr=0x3C, instr_long=1, pc=2.
- Opcode 0xC7 (110 class) is long; opcode 0xE0 (111 class) is short.
  - Required: correct instr_long and pc advance of 2 and 1 respectively.
- Wrap: pc_load_val=0x1FFF, long instruction fetched.
  - Required: mem_addr 0x1FFF then 0x0000, final pc=0x0001.
- pc_load=1 with pc_load_val=0x0100 asserted during FETCH_OPR.
  - Required: no instr_valid, state IDLE next cycle, pc=0x0100, tr unchanged.
  - Then fetch_req: mem_addr=0x0100.
- Timeout: mem_ready held 0 with TIMEOUT=15.
  - Required: fetch_err=1 and busy=0 after 15 wait cycles, pc unchanged.
  - Next fetch_req clears fetch_err.
  - rst low mid-fetch returns all outputs to reset values asynchronously.
